uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of transmit requesters (2..8).
REQ-002 Parameter WORD_SIZE, default 8, bits per UART word.
REQ-003 Parameter TX_RING_SIZE, default 10, depth of the downstream transmit ring; initial credit count.
REQ-004 Parameter MAX_BURST, default 4, maximum words per grant.
REQ-005 Parameter STALL_LIMIT, default 4, idle cycles tolerated from a granted requester before release.
REQ-006 clk  input  1  clock; all logic is rising-edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 req_valid  input  NUM_REQ  requester i has a word on its slice.
REQ-009 req_data  input  NUM_REQ*WORD_SIZE  word of requester i at bits [i*WORD_SIZE +: WORD_SIZE].
REQ-010 req_last  input  NUM_REQ  word of requester i ends its message.
REQ-011 req_ready  output  NUM_REQ  combinational accept to requester i.
REQ-012 nic_data  output  WORD_SIZE  word to the UART controller data input, registered.
REQ-013 nic_write  output  1  one-cycle write strobe to the UART controller, registered.
REQ-014 tx_done  input  1  one-cycle pulse: controller freed one transmit-ring slot.
REQ-015 grant_id  output  clog2(NUM_REQ)  index of current or most recent grant holder.
REQ-016 busy  output  1  high while in GRANT.
REQ-017 credit_err  output  1  sticky: tx_done received while credits were full.

Function
REQ-018 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-019 IDLE: if any req_valid is high, the block SHALL select the first valid index, round-robin, starting at last_grant+1 modulo NUM_REQ; set grant_id; go to GRANT next cycle. No word is accepted in IDLE.
REQ-020 GRANT: req_ready[grant_id] SHALL equal req_valid[grant_id] AND credits>0; all other req_ready bits SHALL be 0. req_ready SHALL be 0 in IDLE.
REQ-021 Transfer = req_valid & req_ready on grant_id. On a transfer in cycle N, nic_write=1 and nic_data=the accepted word in cycle N+1; otherwise nic_write=0 and nic_data holds its last value.
REQ-022 Credits: width clog2(TX_RING_SIZE+1). Transfer alone: -1. tx_done alone: +1. Both in the same cycle: unchanged.
REQ-023 tx_done while credits==TX_RING_SIZE with no transfer SHALL leave credits unchanged and set credit_err.
REQ-024 Burst counter SHALL clear on entry to GRANT and increment per transfer.
REQ-025 GRANT->IDLE SHALL occur after a transfer with req_last=1, or after the MAX_BURST-th transfer; last_grant<=grant_id.
REQ-026 Stall counter SHALL count consecutive GRANT cycles with req_valid[grant_id]=0, clear on any cycle it is 1, and force GRANT->IDLE (last_grant<=grant_id) when it reaches STALL_LIMIT.
REQ-027 Cycles with credits==0 and req_valid high SHALL NOT count as stall.
REQ-028 A granted requester SHALL NOT be re-granted until a new IDLE arbitration; at least one IDLE cycle separates consecutive grants.
REQ-029 req_valid changes of non-granted requesters SHALL have no effect during GRANT.

Reset
REQ-030 On rst: state=IDLE, nic_write=0, nic_data=0, grant_id=0, busy=0, credit_err=0, credits=TX_RING_SIZE, last_grant=NUM_REQ-1, burst and stall counters=0.
REQ-031 rst mid-burst SHALL abort the grant; no nic_write is issued in the cycle after rst, even if a transfer coincided with it.

Verification
REQ-032 Requesters 0 and 2 valid at reset release, each with 2-word message (0xA1,0xA2 / 0xC1,0xC2) -> nic_write sequence 0xA1,0xA2,0xC1,0xC2; grant_id 0 then 2.
REQ-033 Requester 1 holds 6 words, no req_last, requester 3 valid -> 4 words from 1, then grant to 3, then remaining 2 from 1.
REQ-034 TX_RING_SIZE=10, no tx_done, requester 0 streams 12 words -> exactly 10 nic_write pulses, req_ready low at credits=0; one tx_done -> one more word accepted.
REQ-035 Grant to requester 2, req_valid[2] dropped for 4 cycles, requester 0 valid -> release after 4th stall cycle; requester 3 is next in order but, being invalid, grant goes to 0.
REQ-036 Transfer and tx_done in same cycle at credits=5 -> credits stay 5; tx_done at credits=10 -> credit_err=1 until rst.
REQ-037 rst asserted in cycle of a transfer -> next cycle nic_write=0, busy=0, credits=10, grant_id=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// uart_tx_arbiter: round-robin grant of requester word streams onto a credit-limited UART transmit ring.
// Revision 1.0
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int WORD_SIZE    = 8,
  parameter int TX_RING_SIZE = 10,
  parameter int MAX_BURST    = 4,
  parameter int STALL_LIMIT  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WORD_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [WORD_SIZE-1:0]         nic_data,
  output logic                         nic_write,
  input  logic                         tx_done,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         credit_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TX_RING_SIZE + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] CREDIT_FULL = CW'(TX_RING_SIZE);
  localparam logic [BW-1:0] BURST_END   = BW'(MAX_BURST - 1);
  localparam logic [SW-1:0] STALL_END   = SW'(STALL_LIMIT - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [GW-1:0]        last_grant;
  logic [GW-1:0]        sel_idx;
  logic [GW-1:0]        cand;
  logic                 sel_found;
  logic [CW-1:0]        credits;
  logic [BW-1:0]        burst_cnt;
  logic [SW-1:0]        stall_cnt;
  logic                 cur_valid;
  logic                 cur_last;
  logic [WORD_SIZE-1:0] cur_data;
  logic                 credit_ok;
  logic                 xfer;
  logic                 stall;
  logic                 release_grant;

  assign cur_valid = req_valid[grant_id];
  assign cur_last  = req_last[grant_id];
  assign cur_data  = req_data[grant_id*WORD_SIZE +: WORD_SIZE];
  assign credit_ok = (credits != '0);
  assign xfer      = (state == GRANT) && cur_valid && credit_ok;
  // A requester blocked only by missing credits is still valid, so it never counts as stalled.
  assign stall     = (state == GRANT) && !cur_valid;
  assign busy      = (state == GRANT);

  assign release_grant = (xfer && (cur_last || (burst_cnt == BURST_END))) ||
                         (stall && (stall_cnt == STALL_END));

  // Search starts one past the previous holder so every requester gets a turn.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == GRANT) begin
      req_ready[grant_id] = cur_valid && credit_ok;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = GRANT;
      GRANT:   if (release_grant) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      burst_cnt  <= '0;
      stall_cnt  <= '0;
      nic_write  <= 1'b0;
      nic_data   <= '0;
    end else begin
      nic_write <= xfer;
      if (xfer) nic_data <= cur_data;
      if (state == IDLE) begin
        burst_cnt <= '0;
        stall_cnt <= '0;
        if (sel_found) grant_id <= sel_idx;
      end else begin
        if (xfer)  burst_cnt <= burst_cnt + 1'b1;
        if (stall) stall_cnt <= stall_cnt + 1'b1;
        else       stall_cnt <= '0;
        if (release_grant) last_grant <= grant_id;
      end
    end
  end

  // A transfer and a freed slot in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits    <= CREDIT_FULL;
      credit_err <= 1'b0;
    end else if (xfer && !tx_done) begin
      credits <= credits - 1'b1;
    end else if (tx_done && !xfer) begin
      if (credits == CREDIT_FULL) credit_err <= 1'b1;
      else                        credits    <= credits + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter (default parameters).
// Revision 1.0
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WORD_SIZE = 8;
  localparam int GW        = 2;

  logic                         clk       = 1'b0;
  logic                         rst       = 1'b1;
  logic [NUM_REQ-1:0]           req_valid = '0;
  logic [NUM_REQ-1:0]           req_last  = '0;
  logic [NUM_REQ*WORD_SIZE-1:0] req_data  = '0;
  logic                         tx_done   = 1'b0;
  logic [NUM_REQ-1:0]           req_ready;
  logic [WORD_SIZE-1:0]         nic_data;
  logic                         nic_write;
  logic [GW-1:0]                grant_id;
  logic                         busy;
  logic                         credit_err;

  uart_tx_arbiter #(
    .NUM_REQ(4), .WORD_SIZE(8), .TX_RING_SIZE(10), .MAX_BURST(4), .STALL_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .nic_data(nic_data), .nic_write(nic_write), .tx_done(tx_done),
    .grant_id(grant_id), .busy(busy), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WORD_SIZE-1:0] data;
    logic [GW-1:0]        gid;
  } exp_t;

  logic [WORD_SIZE:0] stim [NUM_REQ][32];
  int                 head [NUM_REQ];
  int                 tail [NUM_REQ];
  exp_t               sb[$];
  logic [NUM_REQ-1:0] fire;
  int  vectors = 0, miscompares = 0;
  int  n_writes = 0, nfires = 0, rst_cycles = 0, txd_pend = 0, coinc_at = -1;
  bit  rst_arm = 1'b0, post_rst_chk = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_word(input int r, input logic [WORD_SIZE-1:0] d, input logic last);
    stim[r][tail[r]] = {last, d};
    tail[r]++;
  endtask

  task automatic expect_word(input logic [WORD_SIZE-1:0] d, input logic [GW-1:0] g);
    exp_t e;
    e.data = d;
    e.gid  = g;
    sb.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (head[i] < tail[i]) begin
        req_valid[i] = 1'b1;
        req_data[i*WORD_SIZE +: WORD_SIZE] = stim[i][head[i]][WORD_SIZE-1:0];
        req_last[i]  = stim[i][head[i]][WORD_SIZE];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*WORD_SIZE +: WORD_SIZE] = '0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  // One clock: observe at the falling edge, then advance the requesters after the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    fire = req_valid & req_ready;
    if (post_rst_chk) begin
      check_val("after_rst_nic_write", nic_write, 0);
      check_val("after_rst_busy", busy, 0);
      check_val("after_rst_grant_id", grant_id, 0);
      post_rst_chk = 1'b0;
    end
    if (nic_write) begin
      n_writes++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_val("nic_data", nic_data, e.data);
        check_val("grant_id", grant_id, e.gid);
      end else begin
        check_val("spurious_write", nic_write, 0);
      end
    end
    tx_done = 1'b0;
    if (txd_pend > 0) begin
      tx_done = 1'b1;
      txd_pend--;
    end
    if (coinc_at >= 0 && fire[0] && nfires == coinc_at) tx_done = 1'b1;
    rst = 1'b0;
    if (rst_cycles > 0) begin
      rst = 1'b1;
      rst_cycles--;
    end
    if (rst_arm && fire != '0) begin
      rst = 1'b1;
      rst_arm = 1'b0;
      post_rst_chk = 1'b1;
    end
    nfires += $countones(fire);
    if (rst) begin
      n_writes = 0;
      nfires   = 0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (fire[i]) head[i]++;
    drive();
  endtask

  task automatic do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    coinc_at = -1;
    rst_arm  = 1'b0;
    sb.delete();
    drive();
    rst_cycles = 3;
    repeat (5) step();
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (sb.size() > 0 && n < bound) begin
      step();
      n++;
    end
    check_val("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset();
    #1;
    check_val("reset_nic_write", nic_write, 0);
    check_val("reset_nic_data", nic_data, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_grant_id", grant_id, 0);
    check_val("reset_credit_err", credit_err, 0);
    check_val("reset_req_ready", req_ready, 0);

    // Two short messages, served in round-robin order from requester 0.
    add_word(0, 8'hA1, 1'b0); add_word(0, 8'hA2, 1'b1);
    add_word(2, 8'hC1, 1'b0); add_word(2, 8'hC2, 1'b1);
    expect_word(8'hA1, 2'd0); expect_word(8'hA2, 2'd0);
    expect_word(8'hC1, 2'd2); expect_word(8'hC2, 2'd2);
    drive();
    wait_drain(40);
    repeat (6) step();

    // Burst cap: long message from 1 is split around requester 3.
    do_reset();
    for (int k = 0; k < 6; k++) add_word(1, 8'(8'h10 + k), 1'b0);
    add_word(3, 8'h3F, 1'b1);
    for (int k = 0; k < 4; k++) expect_word(8'(8'h10 + k), 2'd1);
    expect_word(8'h3F, 2'd3);
    expect_word(8'h14, 2'd1); expect_word(8'h15, 2'd1);
    drive();
    wait_drain(80);
    repeat (8) step();
    #1;
    check_val("burst_stalled_out_busy", busy, 0);

    // Credit exhaustion, then one freed slot admits exactly one more word.
    do_reset();
    for (int k = 0; k < 12; k++) add_word(0, 8'(8'h80 + k), (k == 11));
    for (int k = 0; k < 10; k++) expect_word(8'(8'h80 + k), 2'd0);
    drive();
    wait_drain(100);
    repeat (10) step();
    #1;
    check_val("credits_out_writes", n_writes, 10);
    check_val("credits_out_ready", req_ready, 0);
    check_val("credits_out_busy", busy, 1);
    expect_word(8'h8A, 2'd0);
    txd_pend = 1;
    wait_drain(20);
    repeat (10) step();
    #1;
    check_val("one_credit_writes", n_writes, 11);
    check_val("one_credit_ready", req_ready, 0);

    // Stall release after four idle cycles; requester 3 skipped, 0 granted.
    do_reset();
    add_word(2, 8'h21, 1'b0); add_word(2, 8'h22, 1'b0);
    expect_word(8'h21, 2'd2); expect_word(8'h22, 2'd2); expect_word(8'h01, 2'd0);
    drive();
    n = 0;
    while (n_writes < 2 && n < 40) begin
      step();
      n++;
    end
    check_val("stall_setup_writes", n_writes, 2);
    #1;
    check_val("stall_busy_2nd", busy, 1);
    add_word(0, 8'h01, 1'b1);
    step(); step();
    #1;
    check_val("stall_busy_4th", busy, 1);
    step();
    #1;
    check_val("stall_release_busy", busy, 0);
    check_val("stall_release_gid", grant_id, 2);
    step();
    #1;
    check_val("stall_regrant_busy", busy, 1);
    check_val("stall_regrant_gid", grant_id, 0);
    wait_drain(20);

    // Overflowing tx_done is flagged and ignored; coincident transfer/tx_done nets zero.
    do_reset();
    txd_pend = 1;
    repeat (3) step();
    #1;
    check_val("credit_err_set", credit_err, 1);
    for (int k = 0; k < 14; k++) add_word(0, 8'(8'h60 + k), 1'b0);
    for (int k = 0; k < 11; k++) expect_word(8'(8'h60 + k), 2'd0);
    coinc_at = 5;
    drive();
    wait_drain(120);
    repeat (10) step();
    #1;
    check_val("coinc_writes", n_writes, 11);
    check_val("credit_err_sticky", credit_err, 1);

    // Reset landing on a transfer drops that word and aborts the grant.
    do_reset();
    #1;
    check_val("credit_err_cleared", credit_err, 0);
    for (int k = 0; k < 4; k++) add_word(2, 8'(8'h51 + k), (k == 3));
    expect_word(8'h52, 2'd2); expect_word(8'h53, 2'd2); expect_word(8'h54, 2'd2);
    rst_arm = 1'b1;
    drive();
    wait_drain(60);
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
